// File: rtl/srm_pkg.sv
// Shared encodings for the Simple RISC Machine controller: opcode/op fields,
// FSM state encoding, decoded instruction kind and write-back select values.
package srm_pkg;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [3:0] VSEL_NONE  = 4'b0000;
    localparam logic [3:0] VSEL_MDATA = 4'b1000;
    localparam logic [3:0] VSEL_IMM8  = 4'b0100;
    localparam logic [3:0] VSEL_PC    = 4'b0010;
    localparam logic [3:0] VSEL_C     = 4'b0001;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_CALC,
        S_WRITE_REG
    } state_t;

    typedef enum logic [2:0] {
        I_MOV_IMM,
        I_MOV_REG,
        I_ADD,
        I_CMP,
        I_AND,
        I_MVN,
        I_ILLEGAL
    } instr_t;

endpackage

// File: rtl/srm_controller_if.sv
// Datapath control bus driven by the controller (master) into the datapath (slave).
interface srm_controller_if;

    logic [3:0]  vsel;
    logic        write;
    logic [2:0]  writenum;
    logic [2:0]  readnum;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm5;
    logic [15:0] sximm8;

    modport master (
        output vsel, write, writenum, readnum, loada, loadb, loadc, loads,
               asel, bsel, shift, ALUop, sximm5, sximm8
    );

    modport slave (
        input  vsel, write, writenum, readnum, loada, loadb, loadc, loads,
               asel, bsel, shift, ALUop, sximm5, sximm8
    );

endinterface

// File: rtl/srm_instr_decoder.sv
// Combinational field extraction and legality classification of the 16-bit IR.
module srm_instr_decoder
    import srm_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  opcode,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [2:0]  rm,
    output logic [1:0]  sh,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8,
    output logic        legal,
    output instr_t      kind
);

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};

    // NOTE: kind gets a default before the case so every path assigns it and no latch is inferred.
    always_comb begin
        kind = I_ILLEGAL;
        case (opcode)
            OPC_MOV: begin
                if (op == OP_MOV_IMM)      kind = I_MOV_IMM;
                else if (op == OP_MOV_REG) kind = I_MOV_REG;
            end
            OPC_ALU: begin
                case (op)
                    OP_ADD:  kind = I_ADD;
                    OP_CMP:  kind = I_CMP;
                    OP_AND:  kind = I_AND;
                    default: kind = I_MVN;
                endcase
            end
            default: kind = I_ILLEGAL;
        endcase
    end

    assign legal = (kind != I_ILLEGAL);

endmodule

// File: rtl/srm_controller.sv
// Instruction register plus Moore FSM sequencing the SRM datapath through
// operand fetch, execute and write-back.
module srm_controller
    import srm_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       in,
    input  logic              load,
    input  logic              s,
    output logic              w,
    output logic              bad,
    srm_controller_if.master  dp
);

    state_t      state, state_nx;
    logic [15:0] ir;

    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn, rd, rm;
    logic [1:0]  sh;
    logic        legal;
    instr_t      kind;

    srm_instr_decoder u_decoder (
        .ir     (ir),
        .opcode (opcode),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .rm     (rm),
        .sh     (sh),
        .sximm5 (dp.sximm5),
        .sximm8 (dp.sximm8),
        .legal  (legal),
        .kind   (kind)
    );

    assign w        = (state == S_WAIT);
    assign dp.shift = sh;

    // The IR only accepts a new word while idle, so a busy instruction is never corrupted.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir <= '0;
        end else if (load && w) begin
            ir <= in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_WAIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        bad         = 1'b0;
        dp.vsel     = VSEL_NONE;
        dp.write    = 1'b0;
        dp.writenum = 3'd0;
        dp.readnum  = 3'd0;
        dp.loada    = 1'b0;
        dp.loadb    = 1'b0;
        dp.loadc    = 1'b0;
        dp.loads    = 1'b0;
        dp.asel     = 1'b0;
        dp.bsel     = 1'b0;
        dp.ALUop    = 2'b00;

        case (state)
            S_WAIT: begin
                if (s) state_nx = S_DECODE;
            end
            S_DECODE: begin
                if (!legal) begin
                    bad      = 1'b1;
                    state_nx = S_WAIT;
                end else begin
                    case (kind)
                        I_MOV_IMM:        state_nx = S_WRITE_IMM;
                        I_MOV_REG, I_MVN: state_nx = S_GET_B;
                        default:          state_nx = S_GET_A;
                    endcase
                end
            end
            S_WRITE_IMM: begin
                dp.vsel     = VSEL_IMM8;
                dp.writenum = rn;
                dp.write    = 1'b1;
                state_nx    = S_WAIT;
            end
            S_GET_A: begin
                dp.readnum = rn;
                dp.loada   = 1'b1;
                state_nx   = S_GET_B;
            end
            S_GET_B: begin
                dp.readnum = rm;
                dp.loadb   = 1'b1;
                state_nx   = S_CALC;
            end
            S_CALC: begin
                // MOV reg is computed as 0 + sh(Rm) by zeroing the A operand.
                if (opcode == OPC_MOV) begin
                    dp.asel  = 1'b1;
                    dp.ALUop = OP_ADD;
                end else begin
                    dp.ALUop = op;
                end
                if (kind == I_CMP) begin
                    dp.loads = 1'b1;
                    state_nx = S_WAIT;
                end else begin
                    dp.loadc = 1'b1;
                    state_nx = S_WRITE_REG;
                end
            end
            S_WRITE_REG: begin
                dp.vsel     = VSEL_C;
                dp.writenum = rd;
                dp.write    = 1'b1;
                state_nx    = S_WAIT;
            end
            default: state_nx = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_srm_controller.sv
// Scoreboard bench for srm_controller: an instruction model queues the expected
// per-cycle control snapshot, which is popped and compared each cycle.
module tb_srm_controller;

    typedef struct packed {
        logic       w;
        logic       bad;
        logic [3:0] vsel;
        logic       write;
        logic [2:0] writenum;
        logic [2:0] readnum;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] alu_op;
    } ctl_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] instr_in = '0;
    logic        load = 1'b0;
    logic        s = 1'b0;
    logic        w;
    logic        bad;

    logic [15:0] tb_ir = '0;
    ctl_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    srm_controller_if dp_if ();

    srm_controller u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in      (instr_in),
        .load    (load),
        .s       (s),
        .w       (w),
        .bad     (bad),
        .dp      (dp_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic ctl_t observed();
        ctl_t c;
        c.w        = w;
        c.bad      = bad;
        c.vsel     = dp_if.vsel;
        c.write    = dp_if.write;
        c.writenum = dp_if.writenum;
        c.readnum  = dp_if.readnum;
        c.loada    = dp_if.loada;
        c.loadb    = dp_if.loadb;
        c.loadc    = dp_if.loadc;
        c.loads    = dp_if.loads;
        c.asel     = dp_if.asel;
        c.bsel     = dp_if.bsel;
        c.shift    = dp_if.shift;
        c.alu_op   = dp_if.ALUop;
        return c;
    endfunction

    function automatic ctl_t idle_ctl(input logic [1:0] sh);
        ctl_t c = '0;
        c.w     = 1'b1;
        c.shift = sh;
        return c;
    endfunction

    // Reference model: expected control snapshot for every cycle from DECODE back to WAIT.
    function automatic void push_seq(input logic [15:0] ir);
        logic [2:0] opc = ir[15:13];
        logic [1:0] op  = ir[12:11];
        logic [2:0] rn  = ir[10:8];
        logic [2:0] rd  = ir[7:5];
        logic [1:0] sh  = ir[4:3];
        logic [2:0] rm  = ir[2:0];
        bit is_mov = (opc == 3'b110);
        bit is_cmp = (opc == 3'b101) && (op == 2'b01);
        bit legal  = (is_mov && (op == 2'b00 || op == 2'b10)) || (opc == 3'b101);
        ctl_t c;

        c = '0; c.shift = sh; c.bad = !legal;
        exp_q.push_back(c);
        if (legal) begin
            if (is_mov && op == 2'b10) begin
                c = '0; c.shift = sh; c.vsel = 4'b0100; c.write = 1'b1; c.writenum = rn;
                exp_q.push_back(c);
            end else begin
                if (!is_mov && op != 2'b11) begin
                    c = '0; c.shift = sh; c.readnum = rn; c.loada = 1'b1;
                    exp_q.push_back(c);
                end
                c = '0; c.shift = sh; c.readnum = rm; c.loadb = 1'b1;
                exp_q.push_back(c);
                c = '0; c.shift = sh; c.asel = is_mov; c.alu_op = is_mov ? 2'b00 : op;
                c.loadc = !is_cmp; c.loads = is_cmp;
                exp_q.push_back(c);
                if (!is_cmp) begin
                    c = '0; c.shift = sh; c.vsel = 4'b0001; c.write = 1'b1; c.writenum = rd;
                    exp_q.push_back(c);
                end
            end
        end
        exp_q.push_back(idle_ctl(sh));
    endfunction

    // Issue s (optionally with load) at posedge+1, then compare one snapshot per cycle.
    task automatic run(input string name, input logic [15:0] instr, input bit do_load,
                       input int exp_busy, input bit hold_s, input bit poke_load);
        int   idx  = 0;
        int   busy = 0;
        int   drop = 0;
        ctl_t e, o;
        if (do_load) tb_ir = instr;
        push_seq(tb_ir);
        if (hold_s) begin
            drop = exp_q.size();
            push_seq(tb_ir);
        end
        instr_in = instr;
        load     = do_load;
        s        = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = observed();
            check($sformatf("%s[%0d]", name, idx), o, e);
            if (o.w == 1'b0) busy++;
            if (idx == 0) begin
                check({name, " sximm5"}, dp_if.sximm5, {{11{tb_ir[4]}}, tb_ir[4:0]});
                check({name, " sximm8"}, dp_if.sximm8, {{8{tb_ir[7]}}, tb_ir[7:0]});
            end
            if (idx == drop) s = 1'b0;
            if (poke_load && idx == 1) begin
                instr_in = 16'hD07F;
                load     = 1'b1;
            end
            if (poke_load && idx == 3) load = 1'b0;
            if (exp_q.size() > 0) begin
                @(posedge clk); #1;
            end
            idx++;
        end
        check({name, " busy"}, busy, exp_busy);
    endtask

    initial begin
        ctl_t e;

        #12;
        check("reset_ctl", observed(), idle_ctl(2'b00));
        check("reset_sximm8", dp_if.sximm8, 16'h0000);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle_ctl", observed(), idle_ctl(2'b00));

        run("mov_imm", 16'hD3FB, 1'b1, 2, 1'b0, 1'b0);
        check("mov_imm sximm8", dp_if.sximm8, 16'hFFFB);
        run("add",      16'hA148, 1'b1, 5, 1'b0, 1'b0);
        run("cmp",      16'hAC05, 1'b1, 4, 1'b0, 1'b0);
        run("illegal",  16'hE000, 1'b1, 1, 1'b0, 1'b0);
        run("illegal2", 16'hC800, 1'b1, 1, 1'b0, 1'b0);
        run("mov_reg",  16'hC032, 1'b1, 4, 1'b0, 1'b0);
        run("and",      16'hB385, 1'b1, 5, 1'b0, 1'b0);
        run("mvn_poke", 16'hB8DF, 1'b1, 4, 1'b0, 1'b1);
        check("mvn ir kept", dp_if.sximm8, 16'hFFDF);
        run("mvn_again", 16'h0000, 1'b0, 4, 1'b0, 1'b0);
        run("mvn_hold",  16'h0000, 1'b0, 8, 1'b1, 1'b0);

        // Abort an ADD in GET_B with an asynchronous reset.
        instr_in = 16'hA148;
        load     = 1'b1;
        s        = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        s    = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        e = '0; e.readnum = 3'd0; e.loadb = 1'b1; e.shift = 2'b01;
        check("rst_pre_getb", observed(), e);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async", observed(), idle_ctl(2'b00));
        @(posedge clk); #1;
        check("rst_held", observed(), idle_ctl(2'b00));
        #3 reset_n = 1'b1;
        tb_ir = '0;
        @(posedge clk); #1;
        check("rst_release", observed(), idle_ctl(2'b00));
        check("rst_ir_cleared", dp_if.sximm5, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
